// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one outstanding imem request
// at a time and presents a single instruction to the decoder until it retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Jalr,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        MisalignErr
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        // Jalr beats Branch/Jump; JALR target always has bit 0 cleared.
        if (Jalr) begin
            next_pc = ALUResult & ~32'd1;
        end else if (Branch || Jump) begin
            next_pc = PCTarget;
        end else begin
            next_pc = pc_q + 32'd4;
        end

        case (state_q)
            S_REQ: begin
                if (ImemGnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ImemRvalid) begin
                    instr_d = ImemRdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!Stall) begin
                    // PC takes the offending target too, so it is visible in ERR.
                    pc_d    = next_pc;
                    state_d = next_pc[1] ? S_ERR : S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign ImemReq     = (state_q == S_REQ) && !reset;
    assign ImemAddr    = pc_q;
    assign InstrValid  = (state_q == S_HOLD);
    assign Instr       = InstrValid ? instr_q : NOP_INSTR;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign MisalignErr = (state_q == S_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, stall/grant back-pressure,
// redirect priority, PC wrap, misalignment error and reset recovery.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Branch;
    logic        Jump;
    logic        Jalr;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        MisalignErr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .Branch     (Branch),
        .Jump       (Jump),
        .Jalr       (Jalr),
        .PCTarget   (PCTarget),
        .ALUResult  (ALUResult),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRvalid (ImemRvalid),
        .ImemRdata  (ImemRdata),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in a REQ cycle; leaves the DUT in HOLD presenting data.
    task automatic fetch(input int unsigned gnt_wait, input logic [31:0] data,
                         input logic [31:0] exp_addr, input logic spurious);
        check_eq("req_on", 32'(ImemReq), 32'd1);
        check_eq("req_addr", ImemAddr, exp_addr);
        for (int unsigned i = 0; i < gnt_wait; i++) begin
            ImemGnt    = 1'b0;
            ImemRvalid = spurious && (i == 0);
            ImemRdata  = 32'hDEAD_BEEF;
            tick();
            ImemRvalid = 1'b0;
            check_eq("gnt_wait_req", 32'(ImemReq), 32'd1);
            check_eq("gnt_wait_addr", ImemAddr, exp_addr);
            check_eq("gnt_wait_valid", 32'(InstrValid), 32'd0);
        end
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        check_eq("wait_req", 32'(ImemReq), 32'd0);
        check_eq("wait_valid", 32'(InstrValid), 32'd0);
        check_eq("wait_nop", Instr, NOP);
        ImemRvalid = 1'b1;
        ImemRdata  = data;
        tick();
        ImemRvalid = 1'b0;
        ImemRdata  = 32'h0;
        check_eq("hold_valid", 32'(InstrValid), 32'd1);
        check_eq("hold_instr", Instr, data);
        check_eq("hold_pc", PC, exp_addr);
        check_eq("hold_pcplus4", PCPlus4, exp_addr + 32'd4);
        check_eq("hold_req", 32'(ImemReq), 32'd0);
    endtask

    task automatic retire(input logic br, input logic jmp, input logic jr,
                          input logic [31:0] tgt, input logic [31:0] alu);
        Stall     = 1'b0;
        Branch    = br;
        Jump      = jmp;
        Jalr      = jr;
        PCTarget  = tgt;
        ALUResult = alu;
        tick();
        Branch    = 1'b0;
        Jump      = 1'b0;
        Jalr      = 1'b0;
        PCTarget  = 32'h0;
        ALUResult = 32'h0;
    endtask

    initial begin
        reset      = 1'b1;
        Stall      = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        Jalr       = 1'b0;
        PCTarget   = 32'h0;
        ALUResult  = 32'h0;
        ImemGnt    = 1'b0;
        ImemRvalid = 1'b0;
        ImemRdata  = 32'h0;

        tick();
        tick();
        check_eq("rst_req", 32'(ImemReq), 32'd0);
        check_eq("rst_valid", 32'(InstrValid), 32'd0);
        check_eq("rst_err", 32'(MisalignErr), 32'd0);
        check_eq("rst_instr", Instr, NOP);
        check_eq("rst_pc", PC, 32'h0);

        reset = 1'b0;
        #1;
        fetch(0, 32'h0050_0093, 32'h0, 1'b0);

        // Sequential stream 0,4,8,C at one instruction per 3 cycles.
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'h0010_0113, 32'h4, 1'b0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'h0020_0193, 32'h8, 1'b0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'h0030_0213, 32'hC, 1'b0);

        // Stall in HOLD; control inputs must be ignored while not retiring.
        Stall    = 1'b1;
        Jump     = 1'b1;
        PCTarget = 32'h0000_0400;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_valid", 32'(InstrValid), 32'd1);
            check_eq("stall_instr", Instr, 32'h0030_0213);
            check_eq("stall_pc", PC, 32'hC);
            check_eq("stall_req", 32'(ImemReq), 32'd0);
        end
        Jump = 1'b0;
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Withheld grant for 3 cycles with a stray Rvalid in REQ.
        fetch(3, 32'h0040_0293, 32'h10, 1'b1);

        retire(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        fetch(0, 32'h1111_1111, 32'h40, 1'b0);

        retire(1'b0, 1'b1, 1'b1, 32'h80, 32'h201);
        fetch(0, 32'h2222_2222, 32'h200, 1'b0);

        // PC wrap at the top of the address space.
        retire(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        fetch(0, 32'h3333_3333, 32'hFFFF_FFFC, 1'b0);
        check_eq("wrap_pcplus4", PCPlus4, 32'h0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'h4444_4444, 32'h0, 1'b0);

        // Misaligned JALR target: sticky error until reset.
        retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h102);
        for (int unsigned i = 0; i < 10; i++) begin
            ImemGnt    = 1'(i % 2);
            ImemRvalid = 1'(i % 3 == 0);
            check_eq("err_flag", 32'(MisalignErr), 32'd1);
            check_eq("err_req", 32'(ImemReq), 32'd0);
            check_eq("err_valid", 32'(InstrValid), 32'd0);
            check_eq("err_instr", Instr, NOP);
            check_eq("err_pc", PC, 32'h102);
            tick();
        end
        ImemGnt    = 1'b0;
        ImemRvalid = 1'b0;

        reset = 1'b1;
        tick();
        check_eq("rec_err", 32'(MisalignErr), 32'd0);
        check_eq("rec_req_in_reset", 32'(ImemReq), 32'd0);
        check_eq("rec_pc", PC, 32'h0);
        reset = 1'b0;
        #1;
        fetch(1, 32'h5555_5555, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
